// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Shared definitions for the seq_mul_div iterative multiply/divide unit:
//   - operation codes presented on the 'op' port
//   - FSM state encoding
//   - radix-4 Booth digit values and the window-to-digit mapping
// -----------------------------------------------------------------------------
package mul_div_pkg;

  // Operation codes (op[1] selects divide, op[0] selects unsigned).
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_RUN = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Radix-4 Booth digit, range -2..+2.
  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t BOOTH_NEG2 = -3'sd2;
  localparam booth_digit_t BOOTH_NEG1 = -3'sd1;
  localparam booth_digit_t BOOTH_ZERO =  3'sd0;
  localparam booth_digit_t BOOTH_POS1 =  3'sd1;
  localparam booth_digit_t BOOTH_POS2 =  3'sd2;

  // Window {b[2i+1], b[2i], b[2i-1]} -> digit -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic booth_digit_t booth_digit(input logic [2:0] window);
    case (window)
      3'b000, 3'b111: return BOOTH_ZERO;
      3'b001, 3'b010: return BOOTH_POS1;
      3'b011:         return BOOTH_POS2;
      3'b100:         return BOOTH_NEG2;
      default:        return BOOTH_NEG1;  // 3'b101, 3'b110
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// -----------------------------------------------------------------------------
// booth_r4_recode
// Combinational radix-4 Booth recoder. Turns a 3-bit multiplier window into
// the controls that select the partial product from the multiplicand M:
//   zero -> 0, otherwise (two ? 2M : M), negated when neg.
// Ports:
//   window [2:0] in   multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   neg          out  partial product is subtracted
//   zero         out  partial product is zero
//   two          out  partial product uses 2*M
// -----------------------------------------------------------------------------
module booth_r4_recode
  import mul_div_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       zero,
  output logic       two
);

  booth_digit_t digit;

  always_comb begin
    digit = booth_digit(window);
    neg   = digit[2];
    zero  = (digit == BOOTH_ZERO);
    two   = (digit == BOOTH_POS2) || (digit == BOOTH_NEG2);
  end

endmodule

// File: rtl/seq_mul_div.sv
// -----------------------------------------------------------------------------
// seq_mul_div
// Iterative multiply/divide unit beside the datapath ALU. lo feeds RZLO/LO,
// hi feeds RZHI/HI.
//   MUL/MULU : radix-4 Booth, WIDTH/2 iterations plus a final digit/write
//              cycle; finished in the cycle starting WIDTH/2+1 edges after
//              accept.
//   DIV/DIVU : non-restoring on magnitudes, WIDTH iterations, one idle count
//              cycle, then DIV_FIX (remainder correction and sign fix-up);
//              finished WIDTH+2 edges after accept.
// Ports:
//   Clock        in   system clock, rising edge
//   clear        in   asynchronous active-low reset
//   abort        in   (MULDIV_ABORT_EN only) cancel a running operation
//   start        in   request, sampled only in IDLE
//   op [1:0]     in   00 MUL, 01 MULU, 10 DIV, 11 DIVU (sampled with start)
//   a, b         in   operands (sampled with start)
//   busy         out  high in MUL_RUN / DIV_RUN / DIV_FIX
//   finished     out  one-cycle completion pulse (DONE state)
//   lo, hi       out  product low/high, or quotient/remainder
//   div_by_zero  out  valid with finished, cleared on next accept
// Optional feature macro: MULDIV_ABORT_EN (adds the abort input).
// -----------------------------------------------------------------------------
module seq_mul_div
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             finished,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int EXT_W = WIDTH + 2;      // operand extended by two bits
  localparam int ACC_W = 2 * WIDTH + 2;  // accumulator width

  logic abort_req;
`ifdef MULDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [ACC_W-1:0]   acc;       // MUL: running product; DIV: {R, Q}
  logic [ACC_W-1:0]   mcand_sh;  // multiplicand, shifted left 2 per digit
  logic [EXT_W:0]     mplier;    // {b_ext, 0}, shifted right 2 per digit
  logic [CNT_W-1:0]   cnt;

  // ---------------------------------------------------------------------------
  // Operand preparation at accept
  // ---------------------------------------------------------------------------
  logic               op_unsigned, op_is_div, a_neg, b_neg;
  logic [EXT_W-1:0]   a_ext, b_ext;
  logic [ACC_W-1:0]   mcand_init;
  logic [WIDTH-1:0]   a_mag;

  always_comb begin
    op_unsigned = (op == OP_MULU) || (op == OP_DIVU);
    op_is_div   = (op == OP_DIV)  || (op == OP_DIVU);
    a_neg       = !op_unsigned && a[WIDTH-1];
    b_neg       = !op_unsigned && b[WIDTH-1];
    // Unsigned operands get zero extension, so the top Booth window still
    // contributes the +b[WIDTH-1] digit that a plain signed recode would lose.
    a_ext       = {{2{a_neg}}, a};
    b_ext       = {{2{b_neg}}, b};
    mcand_init  = {{WIDTH{a_neg}}, a_ext};
    // MIN still fits: its magnitude is 2^(WIDTH-1) as an unsigned value.
    a_mag       = a_neg ? -a : a;
  end

  // ---------------------------------------------------------------------------
  // Multiply step
  // ---------------------------------------------------------------------------
  logic             rc_neg, rc_zero, rc_two;
  logic [ACC_W-1:0] pp_mag, pp, mul_acc_next;

  booth_r4_recode u_recode (
    .window (mplier[2:0]),
    .neg    (rc_neg),
    .zero   (rc_zero),
    .two    (rc_two)
  );

  always_comb begin
    pp_mag       = rc_two ? (mcand_sh << 1) : mcand_sh;
    pp           = rc_zero ? '0 : (rc_neg ? -pp_mag : pp_mag);
    mul_acc_next = acc + pp;
  end

  // ---------------------------------------------------------------------------
  // Divide step and fix-up
  // ---------------------------------------------------------------------------
  logic             q_unsigned, qa_neg, qb_neg, div_zero;
  logic [WIDTH-1:0] d_mag, q_cur, q_new, quo_s, rem_s, div_lo, div_hi;
  logic [EXT_W-1:0] d_ext, r_cur, r_sh, r_new, rem_fix;

  always_comb begin
    q_unsigned = (op_q == OP_MULU) || (op_q == OP_DIVU);
    qa_neg     = !q_unsigned && a_q[WIDTH-1];
    qb_neg     = !q_unsigned && b_q[WIDTH-1];
    d_mag      = qb_neg ? -b_q : b_q;
    d_ext      = {2'b00, d_mag};

    r_cur      = acc[ACC_W-1:WIDTH];
    q_cur      = acc[WIDTH-1:0];
    r_sh       = {r_cur[EXT_W-2:0], q_cur[WIDTH-1]};
    // Non-restoring: subtract while the partial remainder is non-negative,
    // add back otherwise; the quotient bit is the sign of the result.
    r_new      = r_cur[EXT_W-1] ? (r_sh + d_ext) : (r_sh - d_ext);
    q_new      = {q_cur[WIDTH-2:0], ~r_new[EXT_W-1]};

    rem_fix    = r_cur[EXT_W-1] ? (r_cur + d_ext) : r_cur;
    // MIN / -1 wraps back to MIN here, with remainder 0 and no flag.
    quo_s      = (qa_neg ^ qb_neg) ? -q_cur : q_cur;
    rem_s      = qa_neg ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];

    div_zero   = (b_q == '0);
    div_lo     = div_zero ? '1  : quo_s;
    div_hi     = div_zero ? a_q : rem_s;
  end

  // Product bits above 2*WIDTH and remainder bits above WIDTH are always
  // sign/zero extension and carry no information.
  logic unused_bits;
  assign unused_bits = ^{mul_acc_next[ACC_W-1:2*WIDTH], rem_fix[EXT_W-1:WIDTH]};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves one unassigned and infers a latch.
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = op_is_div ? ST_DIV_RUN : ST_MUL_RUN;
      ST_MUL_RUN: if (abort_req)       state_next = ST_IDLE;
                  else if (cnt == '0)  state_next = ST_DONE;
      ST_DIV_RUN: if (abort_req)       state_next = ST_IDLE;
                  else if (cnt == '0)  state_next = ST_DIV_FIX;
      ST_DIV_FIX: state_next = abort_req ? ST_IDLE : ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!clear) state <= ST_IDLE;
    else        state <= state_next;
  end

  assign busy     = (state == ST_MUL_RUN) || (state == ST_DIV_RUN) ||
                    (state == ST_DIV_FIX);
  assign finished = (state == ST_DONE);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      mcand_sh    <= '0;
      mplier      <= '0;
      cnt         <= '0;
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            div_by_zero <= 1'b0;
            mcand_sh    <= mcand_init;
            mplier      <= {b_ext, 1'b0};
            if (op_is_div) begin
              acc <= {{EXT_W{1'b0}}, a_mag};
              cnt <= CNT_W'(WIDTH);
            end else begin
              acc <= '0;
              cnt <= CNT_W'(WIDTH / 2);
            end
          end
        end
        ST_MUL_RUN: begin
          if (!abort_req) begin
            acc      <= mul_acc_next;
            mcand_sh <= mcand_sh << 2;
            mplier   <= mplier >> 2;
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              // Last digit (top window of the extended multiplier) is folded
              // in on the same edge that publishes the product.
              lo <= mul_acc_next[WIDTH-1:0];
              hi <= mul_acc_next[2*WIDTH-1:WIDTH];
            end
          end
        end
        ST_DIV_RUN: begin
          // The cnt==0 cycle performs no step; it keeps the divide latency
          // at WIDTH+2 edges.
          if (!abort_req && cnt != '0) begin
            acc <= {r_new, q_new};
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DIV_FIX: begin
          if (!abort_req) begin
            lo          <= div_lo;
            hi          <= div_hi;
            div_by_zero <= div_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_div
// Directed self-checking bench for seq_mul_div (WIDTH=32). Each scenario task
// drives its own stimulus and compares against hand-computed values.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after a rising edge. Define MULDIV_ABORT_EN to also exercise
// the abort input.
// -----------------------------------------------------------------------------
module tb_seq_mul_div;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, finished, div_by_zero;
  logic [31:0] lo, hi;
`ifdef MULDIV_ABORT_EN
  logic        abort = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, lo, hi;
  } vec_t;

  seq_mul_div #(.WIDTH(32)) dut (
    .Clock       (Clock),
    .clear       (clear),
`ifdef MULDIV_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .finished    (finished),
    .lo          (lo),
    .hi          (hi),
    .div_by_zero (div_by_zero)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  // Present a request on the falling edge; returns right after the accept edge.
  task automatic accept_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge Clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge Clock);
  endtask

  // Called right after the accept edge. lat = index k of the cycle (starting at
  // accept edge + k) in which finished is seen, -1 if never. busy_bad counts
  // cycles where busy disagreed (should be 1 before finished, 0 with it).
  task automatic wait_done(output int lat, output int busy_bad);
    lat = -1; busy_bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clock);
      if (k == 0) start = 1'b0;
      if (finished) begin
        lat = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge Clock);
    end
  endtask

  task automatic test_reset;
    clear = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge Clock);
    tests++;
    if ({busy, finished, div_by_zero} !== 3'b000 || lo !== 32'h0 || hi !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: busy=%b finished=%b dbz=%b lo=%h hi=%h, required all zero",
               busy, finished, div_by_zero, lo, hi);
    end
    clear = 1'b1;
  endtask

  task automatic test_mul;
    vec_t v[6];
    int lat, bb;
    v[0] = '{2'b00, 32'h1000000F, 32'h00000020, 32'h000001E0, 32'h00000002};
    v[1] = '{2'b00, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB, 32'hFFFFFFFF};
    v[2] = '{2'b01, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB, 32'h00000004};
    v[3] = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    v[4] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    v[5] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      accept_op(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bb);
      tests++;
      if (lat !== 17 || bb !== 0) begin
        fails++;
        $display("FAIL mul[%0d] timing: finished at +%0d busy_errs=%0d, required +17 and 0", i, lat, bb);
      end
      tests++;
      if (lo !== v[i].lo || hi !== v[i].hi || div_by_zero !== 1'b0) begin
        fails++;
        $display("FAIL mul[%0d] result: lo=%h hi=%h dbz=%b, required lo=%h hi=%h dbz=0",
                 i, lo, hi, div_by_zero, v[i].lo, v[i].hi);
      end
      @(negedge Clock);
      tests++;
      if (finished !== 1'b0 || lo !== v[i].lo || hi !== v[i].hi) begin
        fails++;
        $display("FAIL mul[%0d] hold: finished=%b lo=%h hi=%h, required 0 %h %h",
                 i, finished, lo, hi, v[i].lo, v[i].hi);
      end
    end
  endtask

  task automatic test_div;
    vec_t v[7];
    int lat, bb;
    v[0] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    v[1] = '{2'b11, 32'd100,      32'd7,        32'd14,       32'd2};
    v[2] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    v[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    v[4] = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd5};
    v[5] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    v[6] = '{2'b11, 32'd5,        32'd9,        32'd0,        32'd5};
    for (int i = 0; i < 7; i++) begin
      accept_op(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bb);
      tests++;
      if (lat !== 34 || bb !== 0) begin
        fails++;
        $display("FAIL div[%0d] timing: finished at +%0d busy_errs=%0d, required +34 and 0", i, lat, bb);
      end
      tests++;
      if (lo !== v[i].lo || hi !== v[i].hi || div_by_zero !== 1'b0) begin
        fails++;
        $display("FAIL div[%0d] result: lo=%h hi=%h dbz=%b, required lo=%h hi=%h dbz=0",
                 i, lo, hi, div_by_zero, v[i].lo, v[i].hi);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat, bb;
    accept_op(2'b11, 32'h12345678, 32'h0);
    wait_done(lat, bb);
    tests++;
    if (lat !== 34 || lo !== 32'hFFFFFFFF || hi !== 32'h12345678 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL divu_by_zero: lat=%0d lo=%h hi=%h dbz=%b, required 34 ffffffff 12345678 1",
               lat, lo, hi, div_by_zero);
    end
    accept_op(2'b10, 32'hFFFFFFF0, 32'h0);
    wait_done(lat, bb);
    tests++;
    if (lat !== 34 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF0 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL div_by_zero_signed: lat=%0d lo=%h hi=%h dbz=%b, required 34 ffffffff fffffff0 1",
               lat, lo, hi, div_by_zero);
    end
    // Next accept clears the flag but leaves lo/hi alone until completion.
    accept_op(2'b11, 32'd100, 32'd7);
    #1;
    tests++;
    if (div_by_zero !== 1'b0 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF0) begin
      fails++;
      $display("FAIL dbz_clear_on_accept: dbz=%b lo=%h hi=%h, required 0 ffffffff fffffff0",
               div_by_zero, lo, hi);
    end
    wait_done(lat, bb);
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL div_after_dbz: lo=%h hi=%h dbz=%b, required e 2 0", lo, hi, div_by_zero);
    end
  endtask

  task automatic test_start_while_busy;
    int pulses = 0;
    int first = -1;
    accept_op(2'b00, 32'd3, 32'd4);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (k == 0) start = 1'b0;
      if (k == 3) begin start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd1; end
      if (k == 4) start = 1'b0;
      if (finished) begin
        pulses++;
        if (first < 0) first = k;
      end
      @(posedge Clock);
    end
    tests++;
    if (pulses !== 1 || first !== 17) begin
      fails++;
      $display("FAIL start_while_busy pulses: count=%0d first=+%0d, required 1 at +17", pulses, first);
    end
    tests++;
    if (lo !== 32'd12 || hi !== 32'd0) begin
      fails++;
      $display("FAIL start_while_busy result: lo=%h hi=%h, required c 0", lo, hi);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bb;
    accept_op(2'b00, 32'd2, 32'd3);
    wait_done(lat, bb);
    // Request raised during the DONE cycle: the edge leaving DONE ignores it,
    // the following edge accepts it.
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge Clock);
    #1;
    tests++;
    if (busy !== 1'b0 || lo !== 32'd6) begin
      fails++;
      $display("FAIL start_in_done_ignored: busy=%b lo=%h, required 0 6", busy, lo);
    end
    @(posedge Clock);
    wait_done(lat, bb);
    tests++;
    if (lat !== 17 || bb !== 0 || lo !== 32'd30 || hi !== 32'd0) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d busy_errs=%0d lo=%h hi=%h, required 17 0 1e 0",
               lat, bb, lo, hi);
    end
  endtask

  task automatic test_clear_mid_div;
    int lat, bb;
    accept_op(2'b11, 32'd1000, 32'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      if (k == 0) start = 1'b0;
    end
    clear = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || finished !== 1'b0 || lo !== 32'h0 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL clear_mid_div: busy=%b finished=%b lo=%h hi=%h dbz=%b, required all zero",
               busy, finished, lo, hi, div_by_zero);
    end
    repeat (2) @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    tests++;
    if (busy !== 1'b0 || finished !== 1'b0) begin
      fails++;
      $display("FAIL clear_release_idle: busy=%b finished=%b, required 0 0", busy, finished);
    end
    accept_op(2'b00, 32'd3, 32'd4);
    wait_done(lat, bb);
    tests++;
    if (lat !== 17 || lo !== 32'd12 || hi !== 32'd0) begin
      fails++;
      $display("FAIL after_clear_mul: lat=%0d lo=%h hi=%h, required 17 c 0", lat, lo, hi);
    end
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort;
    int lat, bb;
    int pulses = 0;
    accept_op(2'b00, 32'd6, 32'd7);
    wait_done(lat, bb);
    accept_op(2'b00, 32'h1000000F, 32'h00000020);
    for (int k = 0; k < 30; k++) begin
      @(negedge Clock);
      if (k == 0) start = 1'b0;
      if (k == 4) abort = 1'b1;
      if (k == 5) begin
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL abort_busy_drop: busy=%b, required 0", busy);
        end
      end
      if (finished) pulses++;
      @(posedge Clock);
    end
    tests++;
    if (pulses !== 0 || lo !== 32'd42 || hi !== 32'd0) begin
      fails++;
      $display("FAIL abort_result_kept: pulses=%0d lo=%h hi=%h, required 0 2a 0", pulses, lo, hi);
    end
    abort = 1'b1;
    accept_op(2'b00, 32'd5, 32'd5);
    #1;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_start_priority: busy=%b, required 1", busy);
    end
    wait_done(lat, bb);
    tests++;
    if (lat !== 17 || lo !== 32'd25) begin
      fails++;
      $display("FAIL abort_then_mul: lat=%0d lo=%h, required 17 19", lat, lo);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_start_while_busy();
    test_back_to_back();
    test_clear_mid_div();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
